// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : MIPS execute-stage multiply/divide unit owning HI/LO; fixed
//            per-class latency, Cancel flush. MD_MADD_EN adds MADD/MSUB ops.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       md_op,
    input  logic             Start,
    input  logic             Cancel,
    output logic             Busy,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int c_max_cycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

    localparam logic [c_cnt_w-1:0] c_mul_load = c_cnt_w'(MUL_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_load = c_cnt_w'(DIV_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [3:0] c_op_mult  = 4'd1;
    localparam logic [3:0] c_op_multu = 4'd2;
    localparam logic [3:0] c_op_div   = 4'd3;
    localparam logic [3:0] c_op_divu  = 4'd4;
    localparam logic [3:0] c_op_mthi  = 4'd5;
    localparam logic [3:0] c_op_mtlo  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] c_op_madd  = 4'd7;
    localparam logic [3:0] c_op_maddu = 4'd8;
    localparam logic [3:0] c_op_msub  = 4'd9;
    localparam logic [3:0] c_op_msubu = 4'd10;
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_res_hi;
    logic [WIDTH-1:0]   r_res_lo;
    logic               r_res_wr;

    logic               w_accept;
    logic [c_cnt_w-1:0] w_load;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic               w_res_wr;
    logic               w_wr_hi;
    logic               w_wr_lo;

    // Full-width products: operands are pre-extended so a 2*WIDTH multiply
    // yields the exact signed or unsigned result.
    logic [2*WIDTH-1:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx;
    logic [2*WIDTH-1:0] w_prod_s, w_prod_u;

    assign w_a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
    assign w_b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
    assign w_a_zx   = {{WIDTH{1'b0}}, A};
    assign w_b_zx   = {{WIDTH{1'b0}}, B};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = w_a_zx * w_b_zx;

    // A zero divisor is replaced by 1 so the divider never sees it; the
    // result is discarded anyway.
    logic [WIDTH-1:0] w_divisor;
    logic [WIDTH-1:0] w_q_u, w_r_u;
    logic [WIDTH-1:0] w_abs_a, w_abs_b, w_q_mag, w_r_mag;
    logic [WIDTH-1:0] w_q_s, w_r_s;

    assign w_divisor = (B == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : B;
    assign w_q_u     = A / w_divisor;
    assign w_r_u     = A % w_divisor;

    // Sign-magnitude divide; the most-negative / -1 case falls out naturally
    // as quotient 0x80..0 with remainder 0.
    assign w_abs_a = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign w_abs_b = w_divisor[WIDTH-1] ? (~w_divisor + 1'b1) : w_divisor;
    assign w_q_mag = w_abs_a / w_abs_b;
    assign w_r_mag = w_abs_a % w_abs_b;
    assign w_q_s   = (A[WIDTH-1] ^ w_divisor[WIDTH-1]) ? (~w_q_mag + 1'b1) : w_q_mag;
    assign w_r_s   = A[WIDTH-1] ? (~w_r_mag + 1'b1) : w_r_mag;

`ifdef MD_MADD_EN
    logic [2*WIDTH-1:0] w_acc;
    assign w_acc = {Hi, Lo};
`endif

    assign w_accept = Start && !Cancel && (r_state == S_IDLE);
    assign Busy     = (r_state == S_RUN);

    // Operation decode and result datapath
    always_comb begin
        w_load   = '0;
        w_res_hi = '0;
        w_res_lo = '0;
        w_res_wr = 1'b0;
        w_wr_hi  = 1'b0;
        w_wr_lo  = 1'b0;
        case (md_op)
            c_op_mult: begin
                {w_res_hi, w_res_lo} = w_prod_s;
                w_res_wr = 1'b1;
                w_load   = c_mul_load;
            end
            c_op_multu: begin
                {w_res_hi, w_res_lo} = w_prod_u;
                w_res_wr = 1'b1;
                w_load   = c_mul_load;
            end
            c_op_div: begin
                w_res_hi = w_r_s;
                w_res_lo = w_q_s;
                w_res_wr = (B != '0);
                w_load   = c_div_load;
            end
            c_op_divu: begin
                w_res_hi = w_r_u;
                w_res_lo = w_q_u;
                w_res_wr = (B != '0);
                w_load   = c_div_load;
            end
            c_op_mthi: w_wr_hi = 1'b1;
            c_op_mtlo: w_wr_lo = 1'b1;
`ifdef MD_MADD_EN
            c_op_madd: begin
                {w_res_hi, w_res_lo} = w_acc + w_prod_s;
                w_res_wr = 1'b1;
                w_load   = c_mul_load;
            end
            c_op_maddu: begin
                {w_res_hi, w_res_lo} = w_acc + w_prod_u;
                w_res_wr = 1'b1;
                w_load   = c_mul_load;
            end
            c_op_msub: begin
                {w_res_hi, w_res_lo} = w_acc - w_prod_s;
                w_res_wr = 1'b1;
                w_load   = c_mul_load;
            end
            c_op_msubu: begin
                {w_res_hi, w_res_lo} = w_acc - w_prod_u;
                w_res_wr = 1'b1;
                w_load   = c_mul_load;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && (w_load != '0)) w_state_nxt = S_RUN;
            S_RUN:  if (Cancel || (r_count == c_cnt_one)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Counter, pending result and HI/LO. Cancel beats a same-edge completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_res_wr <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
        end else if (r_state == S_RUN) begin
            if (Cancel) begin
                r_count  <= '0;
                r_res_wr <= 1'b0;
            end else begin
                r_count <= r_count - c_cnt_one;
                if ((r_count == c_cnt_one) && r_res_wr) begin
                    Hi <= r_res_hi;
                    Lo <= r_res_lo;
                end
            end
        end else if (w_accept) begin
            if (w_wr_hi) Hi <= A;
            if (w_wr_lo) Lo <= A;
            if (w_load != '0) begin
                r_count  <= w_load;
                r_res_hi <= w_res_hi;
                r_res_lo <= w_res_lo;
                r_res_wr <= w_res_wr;
            end
        end
    end

endmodule
`default_nettype wire
